// File: rtl/pc_sequencer_if.sv
// Sequencer-facing bundle: decoder/ALU/LUT-write controls in, ROM address and status out.
interface pc_sequencer_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned IDX_W = 3
);
  logic             start;
  logic             halt_req;
  logic             is_branch;
  logic             is_store;
  logic [IDX_W-1:0] lut_idx;
  logic             jump_flag;
  logic             lut_wr_en;
  logic [IDX_W-1:0] lut_wr_idx;
  logic [PC_W-1:0]  lut_wr_addr;
  logic [PC_W-1:0]  pc;
  logic             instr_valid;
  logic             reg_wr_en;
  logic             busy;
  logic             done;
  logic [15:0]      instr_count;

  modport master (
    output start, halt_req, is_branch, is_store, lut_idx, jump_flag,
           lut_wr_en, lut_wr_idx, lut_wr_addr,
    input  pc, instr_valid, reg_wr_en, busy, done, instr_count
  );

  modport slave (
    input  start, halt_req, is_branch, is_store, lut_idx, jump_flag,
           lut_wr_en, lut_wr_idx, lut_wr_addr,
    output pc, instr_valid, reg_wr_en, busy, done, instr_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC and FETCH/EXEC/WB sequencer with a small branch-target LUT; every output is a
// register updated from the single state machine below.
module pc_sequencer #(
  parameter int unsigned    PC_W       = 10,
  parameter int unsigned    LUT_N      = 8,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input logic           clock,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  localparam int unsigned IdxW = $clog2(LUT_N);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StWb, StHalt} state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     cnt_q;
  logic            valid_q, wr_q, busy_q, done_q;
  logic            br_q, st_q;
  logic [IdxW-1:0] idx_q;
  logic [PC_W-1:0] lut_q [LUT_N];

  logic taken;
  logic lut_wr_ok;

  assign taken     = br_q & bus.jump_flag;
  assign lut_wr_ok = bus.lut_wr_en & ((state_q == StIdle) | (state_q == StHalt));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      br_q    <= 1'b0;
      st_q    <= 1'b0;
      idx_q   <= '0;
      for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
    end else begin
      if (lut_wr_ok) lut_q[bus.lut_wr_idx] <= bus.lut_wr_addr;
      unique case (state_q)
        StIdle, StHalt: begin
          if (bus.start) begin
            state_q <= StFetch;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StFetch: begin
          state_q <= StExec;
          valid_q <= 1'b1;
        end
        StExec: begin
          valid_q <= 1'b0;
          br_q    <= bus.is_branch;
          st_q    <= bus.is_store;
          idx_q   <= bus.lut_idx;
          if (bus.halt_req) begin
            state_q <= StHalt;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= StWb;
            // Strobe is registered on entry to WB from the values being latched now.
            wr_q    <= ~bus.is_branch & ~bus.is_store;
          end
        end
        StWb: begin
          wr_q <= 1'b0;
          if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
          if (taken) begin
            pc_q    <= lut_q[idx_q];
            state_q <= StFetch;
          end else if (pc_q == '1) begin
            // End of address space: stop rather than wrap to 0.
            state_q <= StHalt;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pc_q    <= pc_q + 1'b1;
            state_q <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.reg_wr_en   = wr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: a program table plays the decoder/ALU; expected EXEC/WB/HALT events are
// queued per program and a negedge monitor pops and compares them as the DUT shows them.
module tb_pc_sequencer;
  localparam int EvExec = 0;
  localparam int EvWb   = 1;
  localparam int EvHalt = 2;

  typedef struct {
    int kind;
    int pc;
    int cnt;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pc_sequencer_if #(.PC_W(10), .IDX_W(3)) bus ();

  pc_sequencer #(.PC_W(10), .LUT_N(8), .START_ADDR(10'd0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic       p_halt [1024];
  logic       p_br   [1024];
  logic       p_st   [1024];
  logic       p_jf   [1024];
  logic [2:0] p_idx  [1024];

  int   checks = 0;
  int   errors = 0;
  int   n_exec = 0;
  int   exec_base = 0;
  int   halt_limit = 0;
  logic done_prev = 1'b0;
  ev_t  exp_q [$];

  // Decoder/ALU model driven from the current ROM address; halt_limit forces a halt on the
  // Nth EXEC of a run so that branches back to address 0 terminate.
  always_comb begin
    bus.halt_req  = p_halt[bus.pc] |
                    ((halt_limit != 0) && ((n_exec - exec_base) >= halt_limit));
    bus.is_branch = p_br[bus.pc];
    bus.is_store  = p_st[bus.pc];
    bus.lut_idx   = p_idx[bus.pc];
    bus.jump_flag = p_jf[bus.pc];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input int pc, input int cnt);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d pc 0x%0h expected none at %0t",
               kind, pc, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.pc != pc || (kind == EvHalt && e.cnt != cnt)) begin
        errors++;
        $display("FAIL event: got kind %0d pc 0x%0h cnt %0d expected kind %0d pc 0x%0h cnt %0d",
                 kind, pc, cnt, e.kind, e.pc, e.cnt);
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.instr_valid) begin
        n_exec++;
        expect_ev(EvExec, int'(bus.pc), 0);
      end
      if (bus.reg_wr_en) expect_ev(EvWb, int'(bus.pc), 0);
      if (bus.done && !done_prev) begin
        expect_ev(EvHalt, int'(bus.pc), int'(bus.instr_count));
        chk("busy_at_halt", int'(bus.busy), 0);
      end
    end
    done_prev = bus.done;
  end

  task automatic push(input int kind, input int pc, input int cnt);
    ev_t e;
    e.kind = kind;
    e.pc   = pc;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) begin
      p_halt[i] = 1'b0;
      p_br[i]   = 1'b0;
      p_st[i]   = 1'b0;
      p_jf[i]   = 1'b0;
      p_idx[i]  = 3'd0;
    end
    halt_limit = 0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    exec_base = n_exec;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic lut_write(input logic [2:0] idx, input logic [9:0] addr);
    @(negedge clock);
    bus.lut_wr_en   = 1'b1;
    bus.lut_wr_idx  = idx;
    bus.lut_wr_addr = addr;
    @(negedge clock);
    bus.lut_wr_en   = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    while (!bus.done && cyc < 300) begin
      @(negedge clock);
      cyc++;
    end
    if (!bus.done) chk({name, "_timeout"}, 0, 1);
    repeat (2) @(negedge clock);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  int cyc;
  int wait_n;

  initial begin
    bus.start       = 1'b0;
    bus.lut_wr_en   = 1'b0;
    bus.lut_wr_idx  = 3'd0;
    bus.lut_wr_addr = 10'd0;
    clear_prog();

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_valid", int'(bus.instr_valid), 0);
    chk("rst_wr", int'(bus.reg_wr_en), 0);
    chk("rst_count", int'(bus.instr_count), 0);
    reset = 1'b0;

    // Three plain instructions then halt; done lands 11 edges after the start edge.
    clear_prog();
    p_halt[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(EvExec, i, 0);
      push(EvWb, i, 0);
    end
    push(EvExec, 3, 0);
    push(EvHalt, 3, 3);
    pulse_start();
    wait_done("basic", cyc);
    chk("done_latency", cyc, 11);

    // Taken branch through LUT[5] written in IDLE.
    do_reset();
    lut_write(3'd5, 10'h1A0);
    clear_prog();
    p_br[0] = 1'b1; p_idx[0] = 3'd5; p_jf[0] = 1'b1;
    p_halt[10'h1A0] = 1'b1;
    push(EvExec, 0, 0);
    push(EvExec, 'h1A0, 0);
    push(EvHalt, 'h1A0, 1);
    pulse_start();
    wait_done("br_taken", cyc);

    // Same branch, not taken.
    clear_prog();
    p_br[0] = 1'b1; p_idx[0] = 3'd5; p_jf[0] = 1'b0;
    p_halt[1] = 1'b1;
    push(EvExec, 0, 0);
    push(EvExec, 1, 0);
    push(EvHalt, 1, 1);
    pulse_start();
    wait_done("br_not_taken", cyc);

    // Store: counted but no writeback.
    clear_prog();
    p_st[0] = 1'b1;
    p_halt[1] = 1'b1;
    push(EvExec, 0, 0);
    push(EvExec, 1, 0);
    push(EvHalt, 1, 1);
    pulse_start();
    wait_done("store", cyc);

    // Branch to the last address; a plain instruction there halts instead of wrapping.
    lut_write(3'd6, 10'h3FF);
    clear_prog();
    p_br[0] = 1'b1; p_idx[0] = 3'd6; p_jf[0] = 1'b1;
    push(EvExec, 0, 0);
    push(EvExec, 'h3FF, 0);
    push(EvWb, 'h3FF, 0);
    push(EvHalt, 'h3FF, 2);
    pulse_start();
    wait_done("pc_top", cyc);
    repeat (3) @(negedge clock);
    chk("pc_top_hold", int'(bus.pc), 'h3FF);
    chk("pc_top_done", int'(bus.done), 1);

    // Reset during EXEC of the second instruction.
    clear_prog();
    push(EvExec, 0, 0);
    push(EvWb, 0, 0);
    push(EvExec, 1, 0);
    pulse_start();
    wait_n = 0;
    while ((n_exec - exec_base) < 2 && wait_n < 50) begin
      @(negedge clock);
      #1;
      wait_n++;
    end
    chk("rst_mid_reached_exec2", int'(bus.instr_valid), 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_pc", int'(bus.pc), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_valid", int'(bus.instr_valid), 0);
    chk("rst_mid_count", int'(bus.instr_count), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_mid_queue_drained", exp_q.size(), 0);
    chk("rst_mid_wr", int'(bus.reg_wr_en), 0);

    // LUT[5] must be cleared: taken branch lands back on 0; halt on the second EXEC.
    clear_prog();
    p_br[0] = 1'b1; p_idx[0] = 3'd5; p_jf[0] = 1'b1;
    halt_limit = 2;
    push(EvExec, 0, 0);
    push(EvExec, 0, 0);
    push(EvHalt, 0, 1);
    pulse_start();
    wait_done("lut_cleared", cyc);

    // Start and LUT write while busy are both ignored.
    clear_prog();
    p_br[1] = 1'b1; p_idx[1] = 3'd2; p_jf[1] = 1'b1;
    halt_limit = 3;
    push(EvExec, 0, 0);
    push(EvWb, 0, 0);
    push(EvExec, 1, 0);
    push(EvExec, 0, 0);
    push(EvHalt, 0, 2);
    pulse_start();
    @(negedge clock);
    bus.start       = 1'b1;
    bus.lut_wr_en   = 1'b1;
    bus.lut_wr_idx  = 3'd2;
    bus.lut_wr_addr = 10'h055;
    @(negedge clock);
    bus.start       = 1'b0;
    bus.lut_wr_en   = 1'b0;
    wait_done("busy_ignore", cyc);

    // In HALT the same write is accepted together with start.
    clear_prog();
    p_br[1] = 1'b1; p_idx[1] = 3'd2; p_jf[1] = 1'b1;
    p_halt[10'h055] = 1'b1;
    push(EvExec, 0, 0);
    push(EvWb, 0, 0);
    push(EvExec, 1, 0);
    push(EvExec, 'h055, 0);
    push(EvHalt, 'h055, 2);
    @(negedge clock);
    exec_base       = n_exec;
    bus.start       = 1'b1;
    bus.lut_wr_en   = 1'b1;
    bus.lut_wr_idx  = 3'd2;
    bus.lut_wr_addr = 10'h055;
    @(negedge clock);
    bus.start       = 1'b0;
    bus.lut_wr_en   = 1'b0;
    wait_done("halt_write", cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
